// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types and constants for the bomb scheduler
package bomb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FUSE, S_BLAST} slot_state_t;

  localparam int GRID_DIM = 16;
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam int FUSE_TICKS_DEF  = 120;
  localparam int BLAST_TICKS_DEF = 30;
  // slot counters are sized for the default tick constants
  localparam int CNT_W = $clog2(((FUSE_TICKS_DEF > BLAST_TICKS_DEF) ?
                                 FUSE_TICKS_DEF : BLAST_TICKS_DEF) + 1);

  typedef struct packed {
    slot_state_t      state;
    logic [7:0]       cor;
    logic             owner;
    logic [CNT_W-1:0] cnt;
  } slot_t;

endpackage

// File: rtl/blast_pattern.sv
// rtl/blast_pattern.sv - combinational cross-shaped blast mask for one cell
module blast_pattern
  import bomb_pkg::*;
#(
  parameter int RANGE = 2
) (
  input  logic [7:0]   cor_i,
  output logic [255:0] mask_o
);

  logic [3:0] row, col;
  assign row = cor_i[7:4];
  assign col = cor_i[3:0];

  // arms stop at the grid edge instead of wrapping into the next row/column
  always_comb begin
    mask_o = '0;
    mask_o[cor_i] = 1'b1;
    for (int d = 1; d <= RANGE; d++) begin
      if (int'(col) + d <= GRID_DIM - 1) mask_o[{row, col + 4'(d)}] = 1'b1;
      if (int'(col) - d >= 0)            mask_o[{row, col - 4'(d)}] = 1'b1;
      if (int'(row) + d <= GRID_DIM - 1) mask_o[{row + 4'(d), col}] = 1'b1;
      if (int'(row) - d >= 0)            mask_o[{row - 4'(d), col}] = 1'b1;
    end
  end

endmodule

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - shared bomb slot pool, fuse/blast timers, explode map
// Optional chain reaction (fuse bombs caught in a blast detonate) with BOMB_CHAIN_REACT_EN.
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int N_SLOTS        = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int FUSE_TICKS     = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS    = BLAST_TICKS_DEF,
  parameter int RANGE          = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         game_active,
  input  logic         p1_place,
  input  logic [7:0]   p1_cor,
  input  logic         p2_place,
  input  logic [7:0]   p2_cor,
  output logic         p1_grant,
  output logic         p2_grant,
  output logic [255:0] bomb_map,
  output logic [255:0] o_explode
);

  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  slot_t          slot_q [N_SLOTS];
  slot_t          slot_d [N_SLOTS];
  logic [255:0]   pat    [N_SLOTS];
  logic           rr_q, rr_d;
  logic           g1_q, g1_d, g2_q, g2_d;
  logic [255:0]   expl_q, expl_d;

  int             cnt1, cnt2, nfree;
  logic [SW-1:0]  f0, f1, s1, s2;
  logic           busy1, busy2, e1, e2, take1, take2;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_pat
    blast_pattern #(.RANGE(RANGE)) u_pat (.cor_i(slot_q[i].cor), .mask_o(pat[i]));
  end

  // eligibility and free-slot search look only at registered state, so a slot
  // expiring this cycle is still counted busy
  always_comb begin
    cnt1 = 0; cnt2 = 0; nfree = 0;
    f0 = '0; f1 = '0;
    busy1 = 1'b0; busy2 = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_q[i].state != S_IDLE) begin
        if (slot_q[i].owner == P1) cnt1++;
        else                       cnt2++;
        if (slot_q[i].cor == p1_cor) busy1 = 1'b1;
        if (slot_q[i].cor == p2_cor) busy2 = 1'b1;
      end else begin
        if (nfree == 0)      f0 = SW'(i);
        else if (nfree == 1) f1 = SW'(i);
        nfree++;
      end
    end
    e1 = game_active && p1_place && (cnt1 < MAX_PER_PLAYER) && !busy1;
    e2 = game_active && p2_place && (cnt2 < MAX_PER_PLAYER) && !busy2;

    take1 = 1'b0; take2 = 1'b0;
    s1 = f0; s2 = f0;
    rr_d = rr_q;
    if (e1 && e2) begin
      if (nfree >= 2 && p1_cor != p2_cor) begin
        take1 = 1'b1; take2 = 1'b1; s2 = f1;
      end else if (nfree >= 1) begin
        take1 = (rr_q == P1);
        take2 = (rr_q == P2);
        rr_d  = ~rr_q;
      end
    end else begin
      take1 = e1 && (nfree >= 1);
      take2 = e2 && (nfree >= 1);
    end
  end

  always_comb begin
    expl_d = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].state == S_BLAST) expl_d = expl_d | pat[i];
      case (slot_q[i].state)
        S_FUSE: begin
`ifdef BOMB_CHAIN_REACT_EN
          if (expl_q[slot_q[i].cor]) begin
            slot_d[i].state = S_BLAST;
            slot_d[i].cnt   = CNT_W'(BLAST_TICKS);
          end else
`endif
          if (tick) begin
            if (slot_q[i].cnt == CNT_W'(1)) begin
              slot_d[i].state = S_BLAST;
              slot_d[i].cnt   = CNT_W'(BLAST_TICKS);
            end else begin
              slot_d[i].cnt = slot_q[i].cnt - 1'b1;
            end
          end
        end
        S_BLAST: begin
          if (tick) begin
            slot_d[i].cnt = slot_q[i].cnt - 1'b1;
            if (slot_q[i].cnt == CNT_W'(1)) slot_d[i].state = S_IDLE;
          end
        end
        default: ;
      endcase
    end
    // new placements are written last so a same-cycle tick never touches them
    if (take1) begin
      slot_d[s1].state = S_FUSE;
      slot_d[s1].cor   = p1_cor;
      slot_d[s1].owner = P1;
      slot_d[s1].cnt   = CNT_W'(FUSE_TICKS);
    end
    if (take2) begin
      slot_d[s2].state = S_FUSE;
      slot_d[s2].cor   = p2_cor;
      slot_d[s2].owner = P2;
      slot_d[s2].cnt   = CNT_W'(FUSE_TICKS);
    end
    if (!game_active) begin
      for (int i = 0; i < N_SLOTS; i++) slot_d[i] = '0;
      expl_d = '0;
    end
    g1_d = take1;
    g2_d = take2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
      rr_q   <= P1;
      g1_q   <= 1'b0;
      g2_q   <= 1'b0;
      expl_q <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
      rr_q   <= rr_d;
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      expl_q <= expl_d;
    end
  end

  always_comb begin
    bomb_map = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (slot_q[i].state == S_FUSE) bomb_map[slot_q[i].cor] = 1'b1;
  end

  assign p1_grant  = g1_q;
  assign p2_grant  = g2_q;
  assign o_explode = expl_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - self-checking bench for bomb_scheduler
module tb_bomb_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1, tick = 1'b0, game_active = 1'b0;
  logic         p1_place = 1'b0, p2_place = 1'b0;
  logic [7:0]   p1_cor = '0, p2_cor = '0;
  logic         p1_grant, p2_grant;
  logic [255:0] bomb_map, o_explode;

  always #5 clk = ~clk;

  bomb_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .game_active(game_active),
    .p1_place(p1_place), .p1_cor(p1_cor), .p2_place(p2_place), .p2_cor(p2_cor),
    .p1_grant(p1_grant), .p2_grant(p2_grant), .bomb_map(bomb_map), .o_explode(o_explode)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic         g1;
    logic         g2;
    logic [255:0] bm;
    logic [255:0] ex;
  } exp_t;

  typedef struct {
    logic       p1;
    logic [7:0] c1;
    logic       p2;
    logic [7:0] c2;
    logic       act;
    logic       g1;
    logic       g2;
  } vec_t;

  typedef struct {
    logic [7:0]   cor;
    logic         owner;
    int           place;
    int           bstart;
    logic [255:0] pat;
  } bomb_t;

  exp_t sbq[$];

  task automatic step(input logic rst, input logic act, input logic tk,
                      input logic pa, input logic [7:0] ca,
                      input logic pb, input logic [7:0] cb, input exp_t e);
    exp_t got;
    reset = rst; game_active = act; tick = tk;
    p1_place = pa; p1_cor = ca; p2_place = pb; p2_cor = cb;
    sbq.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0; tick = 1'b0; p1_place = 1'b0; p2_place = 1'b0;
    got = sbq.pop_front();
    checks++;
    if ({p1_grant, p2_grant} !== {got.g1, got.g2}) begin
      failures++;
      $display("FAIL %s grants: got p1=%b p2=%b, expected p1=%b p2=%b",
               got.name, p1_grant, p2_grant, got.g1, got.g2);
    end
    checks++;
    if (bomb_map !== got.bm) begin
      failures++;
      $display("FAIL %s bomb_map: got %h expected %h", got.name, bomb_map, got.bm);
    end
    checks++;
    if (o_explode !== got.ex) begin
      failures++;
      $display("FAIL %s o_explode: got %h expected %h", got.name, o_explode, got.ex);
    end
  endtask

  function automatic exp_t mke(input string nm, input logic g1, input logic g2,
                               input logic [255:0] bm, input logic [255:0] ex);
    exp_t e;
    e.name = nm; e.g1 = g1; e.g2 = g2; e.bm = bm; e.ex = ex;
    return e;
  endfunction

  function automatic vec_t mkv(input logic p1, input logic [7:0] c1, input logic p2,
                               input logic [7:0] c2, input logic act,
                               input logic g1, input logic g2);
    vec_t v;
    v.p1 = p1; v.c1 = c1; v.p2 = p2; v.c2 = c2; v.act = act; v.g1 = g1; v.g2 = g2;
    return v;
  endfunction

  function automatic bomb_t mkb(input logic [7:0] cor, input logic owner, input int place,
                                input int bstart, input logic [255:0] pat);
    bomb_t b;
    b.cor = cor; b.owner = owner; b.place = place; b.bstart = bstart; b.pat = pat;
    return b;
  endfunction

  // reference cross by coordinate distance, range 2, no wrap
  function automatic logic [255:0] xmask(input logic [7:0] c);
    logic [255:0] m;
    int dr, dc;
    m = '0;
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) begin
        dr = r - int'(c[7:4]);
        dc = k - int'(c[3:0]);
        if ((dr == 0 && dc >= -2 && dc <= 2) || (dc == 0 && dr >= -2 && dr <= 2))
          m[r*16 + k] = 1'b1;
      end
    return m;
  endfunction

  // one tick per cycle; bomb b is in FUSE for edges [place, bstart), and its
  // pattern shows in o_explode for edges (bstart, bstart+30]
  task automatic run_timeline(input string nm, input bomb_t b[$], input int last);
    for (int n = 0; n <= last; n++) begin
      logic pa, pb;
      logic [7:0] ca, cb;
      exp_t e;
      pa = 1'b0; pb = 1'b0; ca = '0; cb = '0;
      e = mke($sformatf("%s@%0d", nm, n), 1'b0, 1'b0, '0, '0);
      foreach (b[k]) begin
        if (b[k].place == n) begin
          if (b[k].owner == 1'b0) begin pa = 1'b1; ca = b[k].cor; e.g1 = 1'b1; end
          else                    begin pb = 1'b1; cb = b[k].cor; e.g2 = 1'b1; end
        end
        if (n >= b[k].place && n < b[k].bstart) e.bm[b[k].cor] = 1'b1;
        if (n > b[k].bstart && n <= b[k].bstart + 30) e.ex = e.ex | b[k].pat;
      end
      step(1'b0, 1'b1, 1'b1, pa, ca, pb, cb, e);
    end
  endtask

  logic [7:0] l35 [9] = '{8'h35, 8'h15, 8'h25, 8'h45, 8'h55, 8'h33, 8'h34, 8'h36, 8'h37};
  logic [7:0] lff [5] = '{8'hFF, 8'hFE, 8'hFD, 8'hEF, 8'hDF};

  initial begin
    vec_t tbl[14];
    logic [255:0] bm_m, m35, mff;
    bomb_t bq[$];
    exp_t zero;
    int chain_bs;

    m35 = '0; foreach (l35[i]) m35[l35[i]] = 1'b1;
    mff = '0; foreach (lff[i]) mff[lff[i]] = 1'b1;

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, mke("reset_state", 0, 0, '0, '0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, mke("idle_after_reset", 0, 0, '0, '0));

    tbl[0]  = mkv(1, 8'h11, 1, 8'h11, 1, 1, 0);
    tbl[1]  = mkv(1, 8'h22, 1, 8'h22, 1, 0, 1);
    tbl[2]  = mkv(1, 8'h11, 0, 8'h00, 1, 0, 0);
    tbl[3]  = mkv(1, 8'h33, 0, 8'h00, 1, 1, 0);
    tbl[4]  = mkv(1, 8'h55, 0, 8'h00, 1, 0, 0);
    tbl[5]  = mkv(1, 8'h66, 1, 8'h77, 1, 0, 1);
    tbl[6]  = mkv(0, 8'h00, 1, 8'h88, 1, 0, 0);
    tbl[7]  = mkv(0, 8'h00, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mkv(1, 8'h12, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mkv(1, 8'hAA, 1, 8'hAA, 1, 1, 0);
    tbl[10] = mkv(0, 8'h00, 1, 8'hBB, 1, 0, 1);
    tbl[11] = mkv(1, 8'h12, 1, 8'h13, 0, 0, 0);
    tbl[12] = mkv(1, 8'hCC, 1, 8'hCC, 1, 0, 1);
    tbl[13] = mkv(1, 8'hDD, 1, 8'hEE, 1, 1, 1);

    bm_m = '0;
    for (int i = 0; i < 14; i++) begin
      if (!tbl[i].act) bm_m = '0;
      if (tbl[i].g1) bm_m[tbl[i].c1] = 1'b1;
      if (tbl[i].g2) bm_m[tbl[i].c2] = 1'b1;
      step(1'b0, tbl[i].act, 1'b0, tbl[i].p1, tbl[i].c1, tbl[i].p2, tbl[i].c2,
           mke($sformatf("vec%0d", i), tbl[i].g1, tbl[i].g2, bm_m, '0));
    end

    zero = mke("reset_clear", 0, 0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 8'h41, zero);

    bq.delete();
    bq.push_back(mkb(8'h35, 1'b0, 0, 120, m35));
    run_timeline("single35", bq, 155);

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, zero);
    bq.delete();
    bq.push_back(mkb(8'hFF, 1'b0, 0, 120, mff));
    bq.push_back(mkb(8'h00, 1'b1, 0, 120, xmask(8'h00)));
    bq.push_back(mkb(8'h02, 1'b1, 1, 121, xmask(8'h02)));
    run_timeline("edges", bq, 155);

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, zero);
`ifdef BOMB_CHAIN_REACT_EN
    chain_bs = 122;
`else
    chain_bs = 130;
`endif
    bq.delete();
    bq.push_back(mkb(8'h44, 1'b0, 0, 120, xmask(8'h44)));
    bq.push_back(mkb(8'h46, 1'b0, 10, chain_bs, xmask(8'h46)));
    run_timeline("chain", bq, 165);

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, zero);
    bq.delete();
    bq.push_back(mkb(8'h35, 1'b0, 0, 120, m35));
    run_timeline("midfuse", bq, 50);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, mke("reset_mid_fuse", 0, 0, '0, '0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, mke("after_reset_fuse", 0, 0, '0, '0));

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, zero);
    run_timeline("midblast", bq, 130);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, mke("reset_mid_blast", 0, 0, '0, '0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, mke("after_reset_blast", 0, 0, '0, '0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
